// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter.
// States, owner codes and the abort data word.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

    localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;
    localparam logic [3:0]  STARVE_SAT = 4'd15;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == STARVE_SAT) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU, DMA and memory side signals of the arbiter.
// master: arbiter view; slave: environment view.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ready;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic [DW-1:0] dma_rdata;
    logic          dma_ready;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    logic          grant_dma;
    logic          err;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_ready,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack,
        output grant_dma, err
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack,
        input  grant_dma, err
    );

endinterface

// File: rtl/mem_port_arbiter_timer.sv
// ACCESS watchdog for the arbiter; only built with ARB_TIMEOUT_EN.
// expired_o is high in the TIMEOUT-th consecutive enabled cycle.
`ifdef ARB_TIMEOUT_EN
module arb_timeout_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int          W    = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // count enabled cycles, parked at LAST until cleared
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = enable_i && (cnt_q == LAST);

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Shares one memory between CPU and DMA: CPU priority, bounded DMA starvation.
// Define ARB_TIMEOUT_EN to abort accesses that never see mem_ack.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int DMA_MAX_WAIT = 4,
    parameter int TIMEOUT      = 15
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.master bus
);
    localparam logic [3:0] MAX_WAIT = 4'(DMA_MAX_WAIT);

    arb_state_e    state_q, state_d;
    owner_e        owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] dma_rdata_q, dma_rdata_d;
    logic [3:0]    starve_q, starve_d;
    logic          abort_q, abort_d;
    logic          pick_dma;
    logic          tmo_expired;

`ifdef ARB_TIMEOUT_EN
    arb_timeout_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (state_q != ST_ACCESS),
        .enable_i  (state_q == ST_ACCESS),
        .expired_o (tmo_expired)
    );
`else
    // no watchdog: an access waits for mem_ack forever
    assign tmo_expired = (TIMEOUT < 0);
`endif

    // arbitration, request latching and response capture
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        starve_d    = starve_q;
        abort_d     = abort_q;
        pick_dma    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.cpu_req || bus.dma_req) begin
                    pick_dma = bus.dma_req &&
                               (!bus.cpu_req || (starve_q >= MAX_WAIT));
                    state_d  = ST_ACCESS;
                    abort_d  = 1'b0;
                    if (pick_dma) begin
                        owner_d  = OWN_DMA;
                        we_d     = bus.dma_we;
                        addr_d   = bus.dma_addr;
                        wdata_d  = bus.dma_wdata;
                        starve_d = '0;
                    end else begin
                        owner_d  = OWN_CPU;
                        we_d     = bus.cpu_we;
                        addr_d   = bus.cpu_addr;
                        wdata_d  = bus.cpu_wdata;
                        if (bus.dma_req) begin
                            starve_d = sat_inc(starve_q);
                        end
                    end
                end
            end
            ST_ACCESS: begin
                if (bus.mem_ack) begin
                    state_d = ST_RESP;
                    if (owner_q == OWN_DMA) begin
                        dma_rdata_d = bus.mem_rdata;
                    end else begin
                        cpu_rdata_d = bus.mem_rdata;
                    end
                end else if (tmo_expired) begin
                    state_d = ST_RESP;
                    abort_d = 1'b1;
                    if (owner_q == OWN_DMA) begin
                        dma_rdata_d = DW'(ABORT_DATA);
                    end else begin
                        cpu_rdata_d = DW'(ABORT_DATA);
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state and datapath registers; reset discards any access in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            starve_q    <= '0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            starve_q    <= starve_d;
            abort_q     <= abort_d;
        end
    end

    assign bus.mem_en    = (state_q == ST_ACCESS);
    assign bus.mem_we    = (state_q == ST_ACCESS) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign bus.cpu_ready = (state_q == ST_RESP) && (owner_q == OWN_CPU);
    assign bus.dma_ready = (state_q == ST_RESP) && (owner_q == OWN_DMA);
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dma_rdata = dma_rdata_q;

    assign bus.grant_dma = (state_q != ST_IDLE) && (owner_q == OWN_DMA);
    assign bus.err       = (state_q == ST_RESP) && abort_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
// Vector table + scoreboard, plus reset, idle-ack, timeout and starvation sequences.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXW = 2;
    localparam int TMO  = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(
        .AW           (AW),
        .DW           (DW),
        .DMA_MAX_WAIT (MAXW),
        .TIMEOUT      (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mdata;
        int          waits;
        int          lat;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        sbq[$];
    logic [31:0] last_rd [2];
    vec_t        vecs [6];

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.dma_req   = 1'b0;
        bus.dma_we    = 1'b0;
        bus.dma_addr  = '0;
        bus.dma_wdata = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;
    endtask

    // called at a negedge with the arbiter idle
    task automatic run_txn(input logic port, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] mdata, input int waits,
                           input logic exp_err, input int exp_lat,
                           input string tag);
        exp_t        e;
        int          c;
        int          acc;
        int          we_cnt;
        bit          done;
        logic [31:0] own_rd;
        logic [31:0] oth_rd;
        e.port  = port;
        e.rdata = exp_err ? ABORT_DATA : mdata;
        e.err   = exp_err;
        e.lat   = exp_lat;
        sbq.push_back(e);
        if (port) begin
            bus.dma_req = 1'b1; bus.dma_we = we;
            bus.dma_addr = addr; bus.dma_wdata = wdata;
        end else begin
            bus.cpu_req = 1'b1; bus.cpu_we = we;
            bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        end
        c = 0; acc = 0; we_cnt = 0; done = 0;
        while (!done && c < 40) begin
            @(negedge clk);
            c++;
            bus.mem_ack = 1'b0;
            if (bus.cpu_ready || bus.dma_ready) begin
                done = 1;
                bus.cpu_req = 1'b0;
                bus.dma_req = 1'b0;
                if (sbq.size() == 0) begin
                    chk({tag, " spurious ready"}, 1, 0);
                end else begin
                    e = sbq.pop_front();
                    own_rd = e.port ? bus.dma_rdata : bus.cpu_rdata;
                    oth_rd = e.port ? bus.cpu_rdata : bus.dma_rdata;
                    chk({tag, " latency"}, 64'(c), 64'(e.lat));
                    chk({tag, " ready port"}, bus.dma_ready, e.port);
                    chk({tag, " dual ready"},
                        bus.cpu_ready & bus.dma_ready, 0);
                    chk({tag, " rdata"}, own_rd, e.rdata);
                    chk({tag, " err"}, bus.err, e.err);
                    chk({tag, " other rdata held"}, oth_rd,
                        last_rd[!e.port]);
                    chk({tag, " grant in resp"}, bus.grant_dma, e.port);
                    chk({tag, " mem_en off in resp"}, bus.mem_en, 0);
                    chk({tag, " access cycles"}, 64'(acc), 64'(e.lat - 1));
                    chk({tag, " we cycles"}, 64'(we_cnt),
                        we ? 64'(e.lat - 1) : 64'd0);
                    last_rd[e.port] = e.rdata;
                end
            end else if (bus.mem_en) begin
                acc++;
                if (bus.mem_we) we_cnt++;
                if (acc == 1) begin
                    chk({tag, " mem_addr"}, bus.mem_addr, addr);
                    chk({tag, " grant"}, bus.grant_dma, port);
                    if (we) chk({tag, " mem_wdata"}, bus.mem_wdata, wdata);
                end
                if (acc > waits) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mdata;
                end
            end
        end
        if (!done) begin
            chk({tag, " no ready within bound"}, 0, 1);
            bus.cpu_req = 1'b0;
            bus.dma_req = 1'b0;
            if (sbq.size() != 0) void'(sbq.pop_front());
        end
    endtask

    initial begin : main
        int exp_ord [6];
        int w;
        clear_inputs();
        last_rd[0] = '0;
        last_rd[1] = '0;

        vecs[0] = '{1'b0, 1'b0, 32'h40,       32'h0,
                    32'h12345678, 0, 2};
        vecs[1] = '{1'b1, 1'b1, 32'h80,       32'hA5A5A5A5,
                    32'h0BADF00D, 3, 5};
        vecs[2] = '{1'b0, 1'b1, 32'h100,      32'hCAFEF00D,
                    32'h11111111, 1, 3};
        vecs[3] = '{1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,
                    32'h89ABCDEF, 0, 2};
        vecs[4] = '{1'b0, 1'b0, 32'h0,        32'h0,
                    32'hFFFFFFFF, 6, 8};
        vecs[5] = '{1'b1, 1'b0, 32'h44,       32'h0,
                    32'h00000001, 2, 4};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst mem_en", bus.mem_en, 0);
        chk("rst mem_we", bus.mem_we, 0);
        chk("rst cpu_ready", bus.cpu_ready, 0);
        chk("rst dma_ready", bus.dma_ready, 0);
        chk("rst grant_dma", bus.grant_dma, 0);
        chk("rst err", bus.err, 0);
        chk("rst mem_addr", bus.mem_addr, 0);
        chk("rst cpu_rdata", bus.cpu_rdata, 0);
        rst = 1'b1;
        @(negedge clk);

        // mem_ack in idle with no request
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h55555555;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("idle ack ready", bus.cpu_ready | bus.dma_ready, 0);
            chk("idle ack mem_en", bus.mem_en, 0);
            @(negedge clk);
        end

        // vector table
        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    vecs[i].mdata, vecs[i].waits, 1'b0, vecs[i].lat,
                    $sformatf("vec%0d", i));
            @(negedge clk);
        end

`ifdef ARB_TIMEOUT_EN
        // no ack: abort after TMO access cycles
        run_txn(1'b0, 1'b0, 32'h300, 32'h0, 32'h0, 1000, 1'b1, TMO + 1,
                "timeout");
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h77777777;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("late ack ready", bus.cpu_ready | bus.dma_ready, 0);
        chk("late ack mem_en", bus.mem_en, 0);
        chk("late ack cpu_rdata", bus.cpu_rdata, ABORT_DATA);
        @(negedge clk);
`else
        // no timer: a long wait still completes without err
        run_txn(1'b0, 1'b0, 32'h300, 32'h0, 32'h31415926, 30, 1'b0, 32,
                "long wait");
        chk("long wait err low", bus.err, 0);
        @(negedge clk);
`endif

        // reset in the middle of an access
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b1;
        bus.cpu_addr = 32'h200;
        bus.cpu_wdata = 32'h13572468;
        @(negedge clk);
        chk("pre-rst mem_en", bus.mem_en, 1);
        chk("pre-rst mem_we", bus.mem_we, 1);
        rst = 1'b0;
        #1;
        chk("mid rst mem_en", bus.mem_en, 0);
        chk("mid rst mem_we", bus.mem_we, 0);
        chk("mid rst mem_addr", bus.mem_addr, 0);
        chk("mid rst cpu_rdata", bus.cpu_rdata, 0);
        bus.cpu_req = 1'b0;
        bus.cpu_we  = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid rst no ready", bus.cpu_ready | bus.dma_ready, 0);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("post rst no ready", bus.cpu_ready | bus.dma_ready, 0);
        run_txn(1'b0, 1'b0, 32'h204, 32'h0, 32'h2468ACE0, 0, 1'b0, 2,
                "post rst");
        @(negedge clk);

        // both requests held: DMA forced ahead after MAXW losses
        exp_ord = '{0, 0, 1, 0, 0, 1};
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 32'h400;
        bus.dma_req  = 1'b1;
        bus.dma_addr = 32'h800;
        for (int g = 0; g < 6; g++) begin
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!bus.mem_en && w < 10);
            chk($sformatf("starve g%0d mem_en", g), bus.mem_en, 1);
            chk($sformatf("starve g%0d owner", g), bus.grant_dma,
                64'(exp_ord[g]));
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 32'(g);
            @(negedge clk);
            bus.mem_ack = 1'b0;
            chk($sformatf("starve g%0d ready", g),
                {bus.dma_ready, bus.cpu_ready},
                exp_ord[g] != 0 ? 64'd2 : 64'd1);
        end
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("final idle mem_en", bus.mem_en, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
